// File: rtl/llc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : llc_mem_responder
// Purpose  : Memory-side responder for the LLC memory channel. Accepts line
//            read/write requests, keeps an internal line-array backing store
//            and returns read lines in acceptance order after a fixed latency.
//            Stands in for DRAM during LLC bring-up and SoC simulation.
// Ports    : clk, rst                       clock / async active-high reset
//            llc_mem_req_valid/ready        request handshake
//            llc_mem_req_hwrite             1 = write line, 0 = read line
//            llc_mem_req_hsize/hprot        carried, not interpreted
//            llc_mem_req_addr/line          line address / write data
//            llc_mem_rsp_valid/ready        read response handshake
//            llc_mem_rsp_line               read data
//            oob_err                        sticky out-of-range address flag
//                                           (only with LLC_MEM_OOB_CHECK_EN)
// Config   : define LLC_MEM_OOB_CHECK_EN to add the oob_err output.
// Revision : 1.0 - initial release
// ============================================================================
module llc_mem_responder #(
    parameter int LINE_W          = 128,
    parameter int LINE_ADDR_W     = 28,
    parameter int MEM_DEPTH_LOG2  = 10,
    parameter int LATENCY         = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   llc_mem_req_valid,
    output logic                   llc_mem_req_ready,
    input  logic                   llc_mem_req_hwrite,
    input  logic [2:0]             llc_mem_req_hsize,
    input  logic [1:0]             llc_mem_req_hprot,
    input  logic [LINE_ADDR_W-1:0] llc_mem_req_addr,
    input  logic [LINE_W-1:0]      llc_mem_req_line,
    output logic                   llc_mem_rsp_valid,
    input  logic                   llc_mem_rsp_ready,
    output logic [LINE_W-1:0]      llc_mem_rsp_line
`ifdef LLC_MEM_OOB_CHECK_EN
    ,
    output logic                   oob_err
`endif
);

    localparam int C_PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int C_CNT_W = C_PTR_W + 1;
    localparam int C_TMR_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int C_DEPTH = 1 << MEM_DEPTH_LOG2;

    // Backing store and read queue payload (never reset)
    logic [LINE_W-1:0]         store_q [C_DEPTH];
    logic [LINE_W-1:0]         qline_q [MAX_OUTSTANDING];

    // Read queue control
    logic [C_CNT_W-1:0]        count_q, count_d;
    logic [C_PTR_W-1:0]        head_q,  head_d;
    logic [C_PTR_W-1:0]        tail_q,  tail_d;
    logic [C_TMR_W-1:0]        timer_q [MAX_OUTSTANDING];
    logic [C_TMR_W-1:0]        timer_d [MAX_OUTSTANDING];

    // Registered response outputs
    logic                      rsp_valid_q, rsp_valid_d;
    logic [LINE_W-1:0]         rsp_line_q,  rsp_line_d;

    logic                      w_req_ready;
    logic                      w_req_fire;
    logic                      w_push;
    logic                      w_wr;
    logic                      w_pop;
    logic                      w_head_is_new;
    logic [MEM_DEPTH_LOG2-1:0] w_index;
    logic                      w_unused;

    // Ready depends only on the registered count: a pop this cycle does not
    // open a slot until the next cycle.
    assign w_req_ready = !rst && (count_q < C_CNT_W'(MAX_OUTSTANDING));
    assign w_req_fire  = llc_mem_req_valid && w_req_ready;
    assign w_push      = w_req_fire && !llc_mem_req_hwrite;
    assign w_wr        = w_req_fire &&  llc_mem_req_hwrite;
    assign w_pop       = rsp_valid_q && llc_mem_rsp_ready;
    assign w_index     = llc_mem_req_addr[MEM_DEPTH_LOG2-1:0];

    // Size/protection are carried only; upper address bits alias.
    assign w_unused = &{1'b0, llc_mem_req_hsize, llc_mem_req_hprot, llc_mem_req_addr};

    always_comb begin
        count_d     = count_q;
        head_d      = head_q;
        tail_d      = tail_q;
        rsp_valid_d = 1'b0;
        rsp_line_d  = rsp_line_q;

        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            timer_d[i] = (timer_q[i] != '0) ? timer_q[i] - C_TMR_W'(1) : timer_q[i];
        end

        if (w_push) begin
            timer_d[tail_q] = C_TMR_W'(LATENCY - 1);
            tail_d          = tail_q + C_PTR_W'(1);
        end
        if (w_pop) begin
            head_d = head_q + C_PTR_W'(1);
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CNT_W'(1);
            2'b01:   count_d = count_q - C_CNT_W'(1);
            default: count_d = count_q;
        endcase

        // An entry pushed at this edge cannot be valid yet; otherwise the
        // head becomes visible one edge after its timer has reached zero,
        // which places rsp_valid exactly LATENCY edges after acceptance.
        w_head_is_new = w_push && (head_d == tail_q);
        rsp_valid_d   = (count_d != '0) && !w_head_is_new && (timer_q[head_d] == '0);
        if (rsp_valid_d) begin
            rsp_line_d = qline_q[head_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_line_q  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                timer_q[i] <= '0;
            end
        end else begin
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_line_q  <= rsp_line_d;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                timer_q[i] <= timer_d[i];
            end
        end
    end

    // Store and queue payload: no reset so writes survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            store_q[w_index] <= llc_mem_req_line;
        end
        if (w_push) begin
            qline_q[tail_q] <= store_q[w_index];
        end
    end

    assign llc_mem_req_ready = w_req_ready;
    assign llc_mem_rsp_valid = rsp_valid_q;
    assign llc_mem_rsp_line  = rsp_line_q;

`ifdef LLC_MEM_OOB_CHECK_EN
    logic oob_q;
    logic w_oob;

    assign w_oob = (llc_mem_req_addr >> MEM_DEPTH_LOG2) != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oob_q <= 1'b0;
        end else if (w_req_fire && w_oob) begin
            oob_q <= 1'b1;
        end
    end

    assign oob_err = oob_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_llc_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_llc_mem_responder
// Purpose  : Self-checking bench for llc_mem_responder. A behavioural model
//            (line array + queue of {line, due-cycle}) predicts ready, valid
//            and response data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_llc_mem_responder;

    localparam int LW   = 128;
    localparam int AW   = 28;
    localparam int DL   = 10;
    localparam int LAT  = 4;
    localparam int MAXO = 4;

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          req_valid  = 1'b0;
    logic          req_hwrite = 1'b0;
    logic [2:0]    req_hsize  = 3'd4;
    logic [1:0]    req_hprot  = 2'd0;
    logic [AW-1:0] req_addr   = '0;
    logic [LW-1:0] req_line   = '0;
    logic          rsp_ready  = 1'b0;
    wire           req_ready;
    wire           rsp_valid;
    wire  [LW-1:0] rsp_line;
`ifdef LLC_MEM_OOB_CHECK_EN
    wire           oob_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [LW-1:0] line;
        int            t;
    } ent_t;

    ent_t          q_m[$];
    logic [LW-1:0] mem_m [0:(1<<DL)-1];

    llc_mem_responder #(
        .LINE_W(LW), .LINE_ADDR_W(AW), .MEM_DEPTH_LOG2(DL),
        .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .llc_mem_req_valid (req_valid),
        .llc_mem_req_ready (req_ready),
        .llc_mem_req_hwrite(req_hwrite),
        .llc_mem_req_hsize (req_hsize),
        .llc_mem_req_hprot (req_hprot),
        .llc_mem_req_addr  (req_addr),
        .llc_mem_req_line  (req_line),
        .llc_mem_rsp_valid (rsp_valid),
        .llc_mem_rsp_ready (rsp_ready),
        .llc_mem_rsp_line  (rsp_line)
`ifdef LLC_MEM_OOB_CHECK_EN
        ,
        .oob_err           (oob_err)
`endif
    );

    always #5 clk = ~clk;

    // Model: a read accepted at edge T is due from edge T+LAT onward; the
    // head is visible once due.
    function automatic bit m_valid();
        return (q_m.size() > 0) && (q_m[0].t <= cyc);
    endfunction

    function automatic bit m_ready();
        return !rst && (q_m.size() < MAXO);
    endfunction

    // One clock: apply this cycle's handshakes to the model, return at negedge.
    task automatic tick();
        bit            fire;
        bit            pop;
        logic [DL-1:0] idx;
        ent_t          e;
        fire = req_valid && m_ready();
        pop  = m_valid() && rsp_ready && !rst;
        idx  = req_addr[DL-1:0];
        @(posedge clk);
        cyc++;
        if (pop) void'(q_m.pop_front());
        if (fire) begin
            if (req_hwrite) begin
                mem_m[idx] = req_line;
            end else begin
                e.line = mem_m[idx];
                e.t    = cyc + LAT;
                q_m.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        q_m.delete();
        repeat (3) tick();
        n_tests++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        n_tests++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_tests++;
        if (rsp_line !== '0) begin n_fail++; $display("FAIL reset_rsp_line: got %h want 0", rsp_line); end
`ifdef LLC_MEM_OOB_CHECK_EN
        n_tests++;
        if (oob_err !== 1'b0) begin n_fail++; $display("FAIL reset_oob: got %b want 0", oob_err); end
`endif
        rst = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_write_read();
        logic [LW-1:0] a5;
        int            t_acc;
        int            pulses;
        a5 = {16{8'hA5}};
        req_valid = 1'b1; req_hwrite = 1'b1; req_addr = 'h005; req_line = a5;
        tick();
        req_hwrite = 1'b0;
        tick();
        t_acc = cyc;
        req_valid = 1'b0; rsp_ready = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_tests++;
            if (rsp_valid !== (cyc == t_acc + 4)) begin
                n_fail++;
                $display("FAIL wr_rd_latency: cycle +%0d rsp_valid got %b want %b", k, rsp_valid, (cyc == t_acc + 4));
            end
            if (rsp_valid === 1'b1) begin
                pulses++;
                n_tests++;
                if (rsp_line !== a5) begin n_fail++; $display("FAIL wr_rd_line: got %h want %h", rsp_line, a5); end
            end
        end
        n_tests++;
        if (pulses != 1) begin n_fail++; $display("FAIL wr_rd_count: got %0d responses want 1", pulses); end
    endtask

    task automatic test_fill_backpressure();
        logic [LW-1:0] lines [4];
        logic [LW-1:0] exp_order [4];
        int            seen;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = 8'((i + 1) * 17);
            lines[i] = {16{b}};
        end
        exp_order[0] = lines[1]; exp_order[1] = lines[2];
        exp_order[2] = lines[3]; exp_order[3] = lines[0];
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_hwrite = 1'b1; req_addr = AW'(i + 1); req_line = lines[i];
            tick();
        end
        req_hwrite = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_addr = AW'(i + 1);
            tick();
        end
        n_tests++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_drop: got %b want 0", req_ready); end
        // Fifth read held; head response held under backpressure for 10 cycles
        req_addr = AW'(1);
        for (int k = 0; k < 10; k++) begin
            tick();
            n_tests++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_line !== lines[0]) begin
                n_fail++;
                $display("FAIL backpressure_hold: cyc %0d ready %b valid %b line %h want ready 0 valid 1 line %h",
                         k, req_ready, rsp_valid, rsp_line, lines[0]);
            end
        end
        rsp_ready = 1'b1;
        tick();
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_return: got %b want 1", req_ready); end
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            if (rsp_valid === 1'b1) begin
                n_tests++;
                if (seen >= 4) begin
                    n_fail++; $display("FAIL fill_order: extra response %h", rsp_line);
                end else if (rsp_line !== exp_order[seen]) begin
                    n_fail++; $display("FAIL fill_order: rsp %0d got %h want %h", seen, rsp_line, exp_order[seen]);
                end
                seen++;
            end
            tick();
            if (k == 0) req_valid = 1'b0;
        end
        n_tests++;
        if (seen != 4) begin n_fail++; $display("FAIL fill_count: got %0d responses want 4", seen); end
    endtask

`ifdef LLC_MEM_OOB_CHECK_EN
    task automatic test_oob();
        logic [LW-1:0] l;
        bit            got;
        l = {$urandom(), $urandom(), $urandom(), $urandom()};
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_hwrite = 1'b1; req_addr = AW'(32'h0400_0005); req_line = l;
        tick();
        n_tests++;
        if (oob_err !== 1'b1) begin n_fail++; $display("FAIL oob_set: got %b want 1", oob_err); end
        req_hwrite = 1'b0; req_addr = AW'(5);
        tick();
        req_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                n_tests++;
                if (rsp_line !== l) begin n_fail++; $display("FAIL oob_alias_line: got %h want %h", rsp_line, l); end
            end
        end
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL oob_alias_timeout: got no response want 1"); end
        repeat (3) tick();
        n_tests++;
        if (oob_err !== 1'b1) begin n_fail++; $display("FAIL oob_sticky: got %b want 1", oob_err); end
    endtask
`endif

    task automatic test_reset_mid();
        bit got;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_hwrite = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            req_addr = AW'(i);
            tick();
        end
        req_valid = 1'b0;
        repeat (5) tick();
        n_tests++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid: got %b want 1", rsp_valid); end
        #2 rst = 1'b1;
        q_m.delete();
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async: valid %b ready %b want 0 0", rsp_valid, req_ready);
        end
        tick(); tick();
        rst = 1'b0; rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_tests++;
            if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale: cyc %0d valid %b want 0", k, rsp_valid); end
        end
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", req_ready); end
        req_valid = 1'b1; req_addr = AW'(2);
        tick();
        req_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                n_tests++;
                if (rsp_line !== {16{8'h22}}) begin
                    n_fail++; $display("FAIL rstmid_retained: got %h want %h", rsp_line, {16{8'h22}});
                end
            end
        end
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL rstmid_timeout: got no response want 1"); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1; req_hwrite = 1'b1; req_addr = AW'(i);
            req_line = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
        end
        for (int n = 0; n < 400; n++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_hwrite = ($urandom_range(0, 3) == 0);
            req_addr   = AW'($urandom_range(0, 15));
`ifndef LLC_MEM_OOB_CHECK_EN
            req_addr[AW-1:DL] = (AW-DL)'($urandom());
`endif
            req_line   = {$urandom(), $urandom(), $urandom(), $urandom()};
            rsp_ready  = (n < 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
            tick();
            n_tests++;
            if (req_ready !== m_ready()) begin
                n_fail++; $display("FAIL rnd_ready: cyc %0d got %b want %b", n, req_ready, m_ready());
            end
            n_tests++;
            if (rsp_valid !== m_valid()) begin
                n_fail++; $display("FAIL rnd_valid: cyc %0d got %b want %b", n, rsp_valid, m_valid());
            end
            if (m_valid()) begin
                n_tests++;
                if (rsp_line !== q_m[0].line) begin
                    n_fail++; $display("FAIL rnd_line: cyc %0d got %h want %h", n, rsp_line, q_m[0].line);
                end
            end
        end
        req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_fill_backpressure();
`ifdef LLC_MEM_OOB_CHECK_EN
        test_oob();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
